// File: rtl/fir_ctrl_pkg.sv
// Shared types for the FIR stream controller: FSM states, the 3-bit control beat and the default pipe depth.
// Latency: n/a (types only); backpressure: n/a.
package fir_ctrl_pkg;

  localparam int FIR_LATENCY_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BYP_PKT = 2'd1,
    FIR_PKT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Avalon-ST control bits that travel alongside a sample
  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } ctl_t;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Upstream sink and downstream source Avalon-ST control signals of the FIR stream controller.
// Latency: n/a (wiring only); backpressure: sink_ready / src_ready.
interface fir_stream_ctrl_if;

  logic sink_valid;
  logic sink_sop;
  logic sink_eop;
  logic sink_ready;
  logic src_valid;
  logic src_sop;
  logic src_eop;
  logic src_ready;

  // slave: the controller; master: the surrounding stream environment
  modport slave (
    input  sink_valid, sink_sop, sink_eop, src_ready,
    output sink_ready, src_valid, src_sop, src_eop
  );

  modport master (
    output sink_valid, sink_sop, sink_eop, src_ready,
    input  sink_ready, src_valid, src_sop, src_eop
  );

endinterface

// File: rtl/fir_ctrl_delay_line.sv
// Shift register carrying valid/sop/eop in step with the FIR pipeline.
// Latency: DEPTH shifts; backpressure: holds contents while shift_en is low, flush empties it.
module fir_ctrl_delay_line
  import fir_ctrl_pkg::*;
#(
  parameter int DEPTH = FIR_LATENCY_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic flush,
  input  ctl_t din,
  output ctl_t dout,
  output logic pend
);

  ctl_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (shift_en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

  // beats still queued behind the tail; low means the next shift empties the line
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pend = pend | stage_q[i].vld;
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Per-packet FIR/bypass steering of Avalon-ST control with framing checks and status counters.
// Latency: 0 cycles bypass, FIR_LATENCY advance cycles filtered; backpressure: src_ready stalls sink and the FIR pipe.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int FIR_LATENCY = FIR_LATENCY_DFLT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic             err_clr,
  fir_stream_ctrl_if.slave st,
  output logic             mode_sel,
  output logic             fir_advance,
  output logic             fir_in_valid,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] beat_count,
  output logic             err_framing
);

  state_t state_q, state_d;
  logic   mode_q;
  logic   ready_raw;
  logic   accept;
  logic   byp_fwd;
  logic   err_set;
  logic   line_flush;
  logic   line_pend;
  ctl_t   line_din;
  ctl_t   line_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && st.sink_sop) begin
          if (cfg_enable)        state_d = st.sink_eop ? DRAIN : FIR_PKT;
          else if (!st.sink_eop) state_d = BYP_PKT;
        end
      end
      BYP_PKT: if (accept && st.sink_eop) state_d = IDLE;
      FIR_PKT: if (accept && st.sink_eop) state_d = DRAIN;
      DRAIN:   if (fir_advance && !line_pend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_raw    = 1'b0;
    fir_advance  = 1'b0;
    byp_fwd      = 1'b0;
    line_flush   = 1'b0;
    mode_sel     = (state_q == IDLE) ? cfg_enable : mode_q;
    unique case (state_q)
      IDLE: begin
        // beats without SOP are swallowed regardless of downstream readiness
        ready_raw   = st.sink_sop ? st.src_ready : 1'b1;
        fir_advance = cfg_enable & st.src_ready;
        byp_fwd     = st.sink_sop & ~cfg_enable;
        line_flush  = ~cfg_enable;
      end
      BYP_PKT: begin
        ready_raw  = st.src_ready;
        byp_fwd    = 1'b1;
        line_flush = 1'b1;
      end
      FIR_PKT: begin
        ready_raw   = st.src_ready;
        fir_advance = st.src_ready;
      end
      DRAIN: begin
        fir_advance = st.src_ready;
      end
      default: ;
    endcase

    st.sink_ready = ready_raw & rst_n;
    accept        = st.sink_valid & ready_raw & rst_n;
    fir_in_valid  = accept & mode_sel &
                    ((state_q == FIR_PKT) | ((state_q == IDLE) & st.sink_sop));
    err_set       = accept & (((state_q == IDLE) & ~st.sink_sop) |
                              (((state_q == BYP_PKT) | (state_q == FIR_PKT)) & st.sink_sop));

    // a repeated SOP inside a packet travels on as a plain continuation beat
    line_din.vld = fir_in_valid;
    line_din.sop = fir_in_valid & st.sink_sop & (state_q == IDLE);
    line_din.eop = fir_in_valid & st.sink_eop;

    if (byp_fwd) begin
      st.src_valid = st.sink_valid & rst_n;
      st.src_sop   = st.sink_valid & st.sink_sop & (state_q == IDLE) & rst_n;
      st.src_eop   = st.sink_valid & st.sink_eop & rst_n;
    end else begin
      st.src_valid = line_tail.vld;
      st.src_sop   = line_tail.sop;
      st.src_eop   = line_tail.eop;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      beat_count  <= '0;
      pkt_count   <= '0;
      err_framing <= 1'b0;
    end else begin
      if ((state_q == IDLE) && accept && st.sink_sop) begin
        mode_q     <= cfg_enable;
        beat_count <= CNT_W'(1);
      end else if (accept && (state_q != IDLE)) begin
        beat_count <= beat_count + CNT_W'(1);
      end
      if (st.src_valid && st.src_ready && st.src_eop) pkt_count <= pkt_count + CNT_W'(1);
      if (err_set)      err_framing <= 1'b1;
      else if (err_clr) err_framing <= 1'b0;
    end
  end

  fir_ctrl_delay_line #(
    .DEPTH (FIR_LATENCY)
  ) u_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (fir_advance),
    .flush    (line_flush),
    .din      (line_din),
    .dout     (line_tail),
    .pend     (line_pend)
  );

endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter FIR_LATENCY, default 4: FIR pipeline depth in advance cycles, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 16: width of the status counters.
REQ-003 SHALL have ports, clock and reset first: clk, input, 1, sole clock; rst_n, input, 1, asynchronous active-low reset.
REQ-004 cfg_enable  in  1  CSR filter enable; sampled only at SOP acceptance.
REQ-005 err_clr  in  1  single-cycle pulse that clears err_framing.
REQ-006 sink_valid / sink_sop / sink_eop  in  1 each  upstream Avalon-ST control.
REQ-007 sink_ready  out  1  upstream ready.
REQ-008 src_ready  in  1  downstream ready.
REQ-009 src_valid / src_sop / src_eop  out  1 each  downstream Avalon-ST control.
REQ-010 mode_sel  out  1  external data mux select: 1 = FIR path, 0 = bypass.
REQ-011 fir_advance  out  1  FIR pipeline clock enable.
REQ-012 fir_in_valid  out  1  a sample enters the FIR this cycle.
REQ-013 busy  out  1  state is not IDLE.
REQ-014 pkt_count / beat_count  out  CNT_W each  completed output packets; accepted beats of the current packet.
REQ-015 err_framing  out  1  sticky framing error flag.

Function
REQ-016 States SHALL be IDLE, BYP_PKT, FIR_PKT, DRAIN; accept = sink_valid && sink_ready.
REQ-017 IDLE, accept with sink_sop: SHALL latch mode = cfg_enable and go to FIR_PKT or BYP_PKT; if sink_eop is also set: bypass stays IDLE, filter goes to DRAIN.
REQ-018 IDLE, accept without sink_sop: SHALL drop the beat (sink_ready=1, src_valid=0) and set err_framing.
REQ-019 BYP_PKT: sink_ready=src_ready; src_valid/sop/eop = sink_valid/sop/eop, combinational; accepted EOP -> IDLE.
REQ-020 FIR_PKT: sink_ready=src_ready; accepted EOP -> DRAIN.
REQ-021 DRAIN: sink_ready=0; fir_advance=src_ready; delay line empty -> IDLE, no idle cycle.
REQ-022 Accepted SOP while in BYP_PKT or FIR_PKT SHALL set err_framing and be forwarded as a continuation beat.
REQ-023 In filter mode, fir_advance SHALL equal src_ready, so the whole pipeline stalls on backpressure.
REQ-024 In filter mode, fir_in_valid SHALL equal accept.
REQ-025 Filter mode SHALL carry valid/sop/eop through a FIR_LATENCY-deep delay line that shifts only when fir_advance=1; src_* SHALL be driven from its tail.
REQ-026 Filter-path latency SHALL be exactly FIR_LATENCY advance cycles from accept to src_valid.
REQ-027 mode_sel SHALL equal the latched mode in BYP_PKT, FIR_PKT and DRAIN, and cfg_enable in IDLE.
REQ-028 A cfg_enable change mid-packet SHALL have no effect until the next SOP.
REQ-029 beat_count SHALL load 1 on accepted SOP and increment on other accepted beats; it wraps at 2^CNT_W.
REQ-030 pkt_count SHALL increment on src_valid && src_ready && src_eop; it wraps.
REQ-031 If err_clr and a new error occur in the same cycle, err_framing SHALL be set (set wins).

Reset
REQ-032 rst_n low SHALL force state IDLE, latched mode 0, delay line empty, counters 0, err_framing 0.
REQ-033 During reset, outputs SHALL be: src_valid/sop/eop=0, busy=0, fir_in_valid=0.
REQ-034 A reset mid-packet SHALL discard the packet, with no EOP emitted afterwards.

Structure
REQ-035 State enum and FIR_LATENCY default SHALL live in fir_ctrl_pkg.
REQ-036 The delay line SHALL be sub-module fir_ctrl_delay_line: 3-bit wide, FIR_LATENCY deep, with shift enable and flush.

Verification
REQ-037 cfg_enable=0, 4-beat packet, src_ready=1 -> src_* mirror sink_* in the same cycle; pkt_count=1; beat_count=4.
REQ-038 cfg_enable=1, 4-beat packet, FIR_LATENCY=4 -> src_sop 4 cycles after SOP accept; src_eop 4 cycles after EOP accept; busy low the cycle after.
REQ-039 Filter mode, src_ready low for 3 cycles mid-packet -> fir_advance=0 and sink_ready=0 for 3 cycles; no beat lost or duplicated; total latency +3.
REQ-040 cfg_enable toggled 1->0 mid filter packet -> packet finishes via FIR with mode_sel=1; next packet bypassed.
REQ-041 Beat without SOP in IDLE -> dropped, err_framing=1; err_clr with a simultaneous error -> err_framing stays 1.
REQ-042 rst_n asserted in DRAIN with 2 beats in flight -> no src_eop after release; pkt_count=0.
